// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings for the fetch sequencer: next-PC select codes and FSM states.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_JR  = 2'b10,
    PCSRC_JMP = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_sequencer_redirect_counter.sv
// Saturating event counter used to count applied PC redirects for performance debug.
module redirect_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter owner for the 5-stage pipeline: selects the next fetch address,
// qualifies fetches and holds redirects that arrive while instruction memory stalls.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int              STEP     = 4,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       PC_Src,
  input  logic             Kill,
  input  logic [PC_W-1:0]  Branch_Target,
  input  logic [PC_W-1:0]  Jump_Target,
  input  logic [PC_W-1:0]  JR_Target,
  input  logic             Stall,
  input  logic             Imem_Ready,
  output logic [PC_W-1:0]  PC,
  output logic [PC_W-1:0]  PC_Plus,
  output logic             Fetch_Valid,
  output logic             IF_ID_Flush,
  output logic [CNT_W-1:0] Redirect_Count
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_q, pend_d;
  logic [PC_W-1:0] target;
  logic            redirect;
  logic            cnt_inc;

  always_comb begin
    case (pc_src_e'(PC_Src))
      PCSRC_BR:  target = Branch_Target;
      PCSRC_JR:  target = JR_Target;
      PCSRC_JMP: target = Jump_Target;
      default:   target = PC_Plus;
    endcase
  end

  // A stalled Kill carries stale decode operands, and Kill with the sequential
  // select is not a real redirect, so neither may move the PC.
  assign redirect = Kill & ~Stall & (PC_Src != PCSRC_SEQ);
  assign PC_Plus  = pc_q + PC_W'(STEP);
  assign PC       = pc_q;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
    cnt_inc     = 1'b0;
    Fetch_Valid = 1'b0;
    IF_ID_Flush = 1'b0;
    case (state_q)
      S_BOOT: begin
        IF_ID_Flush = 1'b1;
        state_d     = S_RUN;
      end
      S_RUN: begin
        Fetch_Valid = Imem_Ready;
        IF_ID_Flush = redirect;
        if (!Stall) begin
          if (redirect) begin
            pc_d    = target;
            cnt_inc = 1'b1;
            if (!Imem_Ready) begin
              state_d = S_WAIT;
              pend_d  = 1'b0;
            end
          end else if (Imem_Ready) begin
            pc_d = PC_Plus;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        IF_ID_Flush = pend_q | redirect;
        if (Imem_Ready) begin
          state_d = S_RUN;
          pend_d  = 1'b0;
          // A same-cycle redirect is younger than the held one and wins.
          if (redirect) begin
            pc_d    = target;
            cnt_inc = 1'b1;
          end else if (pend_q) begin
            pc_d    = pend_tgt_q;
            cnt_inc = 1'b1;
          end
        end else if (redirect) begin
          pend_d     = 1'b1;
          pend_tgt_d = target;
        end
      end
      default: begin
        IF_ID_Flush = 1'b1;
        state_d     = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  redirect_counter #(
    .CNT_W(CNT_W)
  ) u_redirect_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (cnt_inc),
    .count(Redirect_Count)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand-written
// wait-state/reset sequences, and randomized traffic against a behavioural model.
module tb_fetch_sequencer;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  PC_Src;
  logic        Kill;
  logic [31:0] Branch_Target, Jump_Target, JR_Target;
  logic        Stall, Imem_Ready;
  logic [31:0] PC, PC_Plus;
  logic        Fetch_Valid, IF_ID_Flush;
  logic [CNT_W-1:0] Redirect_Count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .PC_W(32), .RESET_PC(32'h0000_0000), .STEP(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .PC_Src(PC_Src), .Kill(Kill),
    .Branch_Target(Branch_Target), .Jump_Target(Jump_Target), .JR_Target(JR_Target),
    .Stall(Stall), .Imem_Ready(Imem_Ready), .PC(PC), .PC_Plus(PC_Plus),
    .Fetch_Valid(Fetch_Valid), .IF_ID_Flush(IF_ID_Flush), .Redirect_Count(Redirect_Count)
  );

  typedef struct {
    logic        kill;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic        stall;
    logic        rdy;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        e_flush;
    int          e_cnt;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e_pc, input logic e_valid,
                            input logic e_flush, input int e_cnt);
    check({tag, " PC"}, PC, e_pc);
    check({tag, " PC_Plus"}, PC_Plus, e_pc + 32'd4);
    check({tag, " Fetch_Valid"}, {31'b0, Fetch_Valid}, {31'b0, e_valid});
    check({tag, " IF_ID_Flush"}, {31'b0, IF_ID_Flush}, {31'b0, e_flush});
    check({tag, " Redirect_Count"}, 32'(Redirect_Count), 32'(e_cnt));
  endtask

  // Only the selected target carries the wanted address; the others hold decoys.
  task automatic drive(input logic kill, input logic [1:0] src, input logic [31:0] tgt,
                       input logic stall, input logic rdy);
    Kill          = kill;
    PC_Src        = src;
    Branch_Target = (src == 2'b01) ? tgt : 32'hBAD0_0010;
    JR_Target     = (src == 2'b10) ? tgt : 32'hBAD0_0020;
    Jump_Target   = (src == 2'b11) ? tgt : 32'hBAD0_0030;
    Stall         = stall;
    Imem_Ready    = rdy;
  endtask

  // Behavioural reference: fetch phase flags, PC, one optional held redirect, counter.
  bit          m_boot, m_wait, m_pend;
  logic [31:0] m_pc, m_tgt;
  int          m_cnt;

  function automatic void m_reset();
    m_boot = 1; m_wait = 0; m_pend = 0; m_pc = 32'h0; m_tgt = 32'h0; m_cnt = 0;
  endfunction

  function automatic void m_bump();
    if (m_cnt < CNT_MAX) m_cnt++;
  endfunction

  function automatic void m_step(input logic kill, input logic [1:0] src, input logic [31:0] t,
                                 input logic stall, input logic rdy);
    bit redir = kill && !stall && (src != 2'b00);
    if (m_boot) begin
      m_boot = 0;
    end else if (!m_wait) begin
      if (stall) begin
      end else if (redir) begin
        m_pc = t; m_bump();
        if (!rdy) begin m_wait = 1; m_pend = 0; end
      end else if (rdy) begin
        m_pc = m_pc + 32'd4;
      end else begin
        m_wait = 1;
      end
    end else if (rdy) begin
      if (redir) begin m_pc = t; m_bump(); end
      else if (m_pend) begin m_pc = m_tgt; m_bump(); end
      m_pend = 0; m_wait = 0;
    end else if (redir) begin
      m_pend = 1; m_tgt = t;
    end
  endfunction

  initial begin
    // kill src tgt stall rdy | pc valid flush cnt  (checked before the edge)
    tbl[0]  = '{1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 0}; // BOOT
    tbl[1]  = '{1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 0};
    tbl[2]  = '{1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 32'h4,         1'b1, 1'b0, 0};
    tbl[3]  = '{1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 32'h8,         1'b1, 1'b0, 0};
    tbl[4]  = '{1'b1, 2'd1, 32'h40,        1'b0, 1'b1, 32'hC,         1'b1, 1'b1, 0};
    tbl[5]  = '{1'b1, 2'd1, 32'h100,       1'b0, 1'b1, 32'h40,        1'b1, 1'b1, 1};
    tbl[6]  = '{1'b1, 2'd1, 32'h20,        1'b0, 1'b1, 32'h100,       1'b1, 1'b1, 2};
    tbl[7]  = '{1'b1, 2'd3, 32'h300,       1'b1, 1'b1, 32'h20,        1'b1, 1'b0, 3}; // stall beats kill
    tbl[8]  = '{1'b1, 2'd3, 32'h300,       1'b0, 1'b1, 32'h20,        1'b1, 1'b1, 3};
    tbl[9]  = '{1'b1, 2'd1, 32'h10,        1'b0, 1'b1, 32'h300,       1'b1, 1'b1, 4};
    tbl[10] = '{1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 32'h10,        1'b0, 1'b0, 5}; // -> WAIT
    tbl[11] = '{1'b1, 2'd2, 32'h200,       1'b0, 1'b0, 32'h10,        1'b0, 1'b1, 5}; // captured
    tbl[12] = '{1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 32'h10,        1'b0, 1'b1, 5};
    tbl[13] = '{1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 32'h10,        1'b0, 1'b1, 5}; // apply
    tbl[14] = '{1'b1, 2'd1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h200,       1'b1, 1'b1, 6};
    tbl[15] = '{1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 7};
    tbl[16] = '{1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 7}; // wrapped

    reset = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    #1;
    check_outs("reset", 32'h0, 1'b0, 1'b1, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge clk);
      drive(tbl[i].kill, tbl[i].src, tbl[i].tgt, tbl[i].stall, tbl[i].rdy);
      #1;
      check_outs($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_valid, tbl[i].e_flush, tbl[i].e_cnt);
    end

    // Redirect counter saturation: 10 more redirects from a count of 7.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, 2'd1, 32'h1000 + 32'(i) * 32'd4, 1'b0, 1'b1);
    end
    @(negedge clk);
    drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    #1;
    check_outs("saturate", 32'h1024, 1'b1, 1'b0, CNT_MAX);

    // Reset mid-WAIT_MEM with a held redirect: async, and the redirect is lost.
    @(negedge clk);
    drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 2'd1, 32'h5000, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check("pend flush", {31'b0, IF_ID_Flush}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_outs("async reset", 32'h0, 1'b0, 1'b1, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    #1;
    check_outs("post-reset boot", 32'h0, 1'b0, 1'b1, 0);
    @(negedge clk);
    #1;
    check_outs("post-reset run0", 32'h0, 1'b1, 1'b0, 0);
    @(negedge clk);
    #1;
    check_outs("post-reset run1", 32'h4, 1'b1, 1'b0, 0);

    // Randomized traffic against the reference model from a clean reset.
    @(negedge clk);
    reset = 1'b1;
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic        k, st, rd;
      logic [1:0]  s;
      logic [31:0] t;
      bit          redir;
      if (i > 0) @(negedge clk);
      k  = ($urandom_range(0, 3) == 0);
      s  = k ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
      t  = {$urandom, 2'b00} ^ ((i % 37 == 0) ? 32'hFFFF_FFF0 : 32'h0);
      st = ($urandom_range(0, 4) == 0);
      rd = ($urandom_range(0, 3) != 0);
      drive(k, s, t, st, rd);
      #1;
      redir = k && !st && (s != 2'b00);
      check_outs($sformatf("rand%0d", i), m_pc, !m_boot && !m_wait && rd,
                 m_boot || (m_wait ? (m_pend || redir) : redir), m_cnt);
      @(posedge clk);
      m_step(k, s, t, st, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
